// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// Optional feature macro: MC_ADDI_EN (adds the addi instruction path).
package mc_ctrl_pkg;

    // State register width and state codes.
    typedef logic [3:0] mcState_t;

    localparam mcState_t ST_FETCH     = 4'd0;
    localparam mcState_t ST_DECODE    = 4'd1;
    localparam mcState_t ST_MEM_ADDR  = 4'd2;
    localparam mcState_t ST_MEM_READ  = 4'd3;
    localparam mcState_t ST_MEM_WB    = 4'd4;
    localparam mcState_t ST_MEM_WRITE = 4'd5;
    localparam mcState_t ST_EXECUTE   = 4'd6;
    localparam mcState_t ST_ALU_WB    = 4'd7;
    localparam mcState_t ST_BRANCH    = 4'd8;
    localparam mcState_t ST_JUMP      = 4'd9;
`ifdef MC_ADDI_EN
    localparam mcState_t ST_ADDI_EXEC = 4'd10;
    localparam mcState_t ST_ADDI_WB   = 4'd11;
`endif

    // Primary opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALU source-B select.
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control word, before reset gating and pc_en combining.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
        logic       illegalOp;
    } mcCtrl_t;

    // True when DECODE has a successor state for this opcode.
    function automatic logic isLegalOp(input logic [5:0] op);
        logic legal;
        legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_J);
`ifdef MC_ADDI_EN
        legal = legal || (op == OP_ADDI);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle for the multi-cycle MIPS core.
// Optional feature macro: MC_ADDI_EN (no signals depend on it).
//
// Handshake: mem_ready is the memory's "access complete" indication. The
// controller holds its request (mem_read or mem_write with iord) steady in a
// memory state and treats the cycle in which mem_ready is 1 as the single
// transfer cycle; mem_ready is ignored in every other state.
interface multicycle_control_if;
    import mc_ctrl_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    mcState_t   dbgState;

    // Control unit side.
    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, pc_write, pc_write_cond, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, instr_done, illegal_op, dbgState
    );

    // Datapath / observer side.
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, pc_write, pc_write_cond, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, pc_source, instr_done, illegal_op, dbgState
    );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational state-to-control mapping of the multi-cycle MIPS controller.
// Optional feature macro: MC_ADDI_EN (decodes the two addi states).
module mc_output_decode
    import mc_ctrl_pkg::*;
(
    input  mcState_t   state,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output mcCtrl_t    ctrl
);

    // Moore decode; only FETCH/MEM_WRITE strobes and DECODE's illegal flag look at inputs.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.pcWrite = memReady;
                ctrl.irWrite = memReady;
            end
            ST_DECODE: begin
                ctrl.aluSrcB   = SRCB_IMM_SHL2;
                ctrl.illegalOp = !isLegalOp(opcode);
            end
            ST_MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            ST_MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.memToReg  = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.instrDone = memReady;
            end
            ST_EXECUTE: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.regDst    = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
                ctrl.instrDone   = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSource  = PCSRC_JUMP;
                ctrl.instrDone = 1'b1;
            end
`ifdef MC_ADDI_EN
            ST_ADDI_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            ST_ADDI_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control unit of the multi-cycle MIPS core: state register, next-state
// logic and reset gating of the control word.
// Optional feature macro: MC_ADDI_EN (routes opcode 0x08 through ADDI states).
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    mcState_t stateReg;
    mcState_t stateNext;
    mcCtrl_t  ctrl;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateReg <= ST_FETCH;
        else        stateReg <= stateNext;
    end

    // Next-state selection; memory states wait on mem_ready, unknown opcodes refetch.
    always_comb begin
        stateNext = ST_FETCH;
        case (stateReg)
            ST_FETCH:     stateNext = bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: stateNext = ST_EXECUTE;
                    OP_LW:    stateNext = ST_MEM_ADDR;
                    OP_SW:    stateNext = ST_MEM_ADDR;
                    OP_BEQ:   stateNext = ST_BRANCH;
                    OP_J:     stateNext = ST_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:  stateNext = ST_ADDI_EXEC;
`endif
                    default:  stateNext = ST_FETCH;
                endcase
            end
            // Only lw and sw reach MEM_ADDR, so anything but lw is a store.
            ST_MEM_ADDR:  stateNext = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  stateNext = bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    stateNext = ST_FETCH;
            ST_MEM_WRITE: stateNext = bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXECUTE:   stateNext = ST_ALU_WB;
            ST_ALU_WB:    stateNext = ST_FETCH;
            ST_BRANCH:    stateNext = ST_FETCH;
            ST_JUMP:      stateNext = ST_FETCH;
`ifdef MC_ADDI_EN
            ST_ADDI_EXEC: stateNext = ST_ADDI_WB;
            ST_ADDI_WB:   stateNext = ST_FETCH;
`endif
            default:      stateNext = ST_FETCH;
        endcase
    end

    mc_output_decode uDecode (
        .state    (stateReg),
        .opcode   (bus.opcode),
        .memReady (bus.mem_ready),
        .ctrl     (ctrl)
    );

    // Reset forces every control low asynchronously, aborting any in-flight store.
    mcCtrl_t gated;
    always_comb begin
        gated = '0;
        if (rst_n) gated = ctrl;
    end

    assign bus.pc_write      = gated.pcWrite;
    assign bus.pc_write_cond = gated.pcWriteCond;
    assign bus.pc_en         = gated.pcWrite | (gated.pcWriteCond & bus.zero);
    assign bus.iord          = gated.iord;
    assign bus.mem_read      = gated.memRead;
    assign bus.mem_write     = gated.memWrite;
    assign bus.ir_write      = gated.irWrite;
    assign bus.reg_dst       = gated.regDst;
    assign bus.mem_to_reg    = gated.memToReg;
    assign bus.reg_write     = gated.regWrite;
    assign bus.alu_src_a     = gated.aluSrcA;
    assign bus.alu_src_b     = gated.aluSrcB;
    assign bus.alu_op        = gated.aluOp;
    assign bus.pc_source     = gated.pcSource;
    assign bus.instr_done    = gated.instrDone;
    assign bus.illegal_op    = gated.illegalOp;
    assign bus.dbgState      = stateReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases plus random
// instruction streams against a per-instruction phase model.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   doneSeen;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MC_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef enum int {
        P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE,
        P_EXECUTE, P_ALU_WB, P_BRANCH, P_JUMP, P_ADDI_EXEC, P_ADDI_WB
    } phase_e;

    // Observed outputs packed in one vector:
    // pc_en pc_write pc_write_cond iord mem_read mem_write ir_write reg_dst
    // mem_to_reg reg_write alu_src_a alu_src_b alu_op pc_source instr_done illegal_op
    logic [18:0] obs;
    assign obs = {bus.pc_en, bus.pc_write, bus.pc_write_cond, bus.iord,
                  bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                  bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op};

    function automatic bit legalOp(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h02) || (ADDI_EN && op == 6'h08);
    endfunction

    // Expected control word for one cycle, straight from the state table.
    function automatic logic [18:0] expCtrl(input phase_e ph, input bit mr,
                                            input bit z, input logic [5:0] opc);
        bit pw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, sa, dn, ill;
        bit [1:0] sb, aop, psrc;
        {pw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, sa, dn, ill} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (ph)
            P_FETCH:     begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
            P_DECODE:    begin sb = 2'b11; ill = !legalOp(opc); end
            P_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
            P_MEM_READ:  begin mrd = 1; io = 1; end
            P_MEM_WB:    begin m2r = 1; rw = 1; dn = 1; end
            P_MEM_WRITE: begin mwr = 1; io = 1; dn = mr; end
            P_EXECUTE:   begin sa = 1; aop = 2'b10; end
            P_ALU_WB:    begin rdst = 1; rw = 1; dn = 1; end
            P_BRANCH:    begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; dn = 1; end
            P_JUMP:      begin pw = 1; psrc = 2'b10; dn = 1; end
            P_ADDI_EXEC: begin sa = 1; sb = 2'b10; end
            P_ADDI_WB:   begin rw = 1; dn = 1; end
            default:     ;
        endcase
        return {pw | (pwc & z), pw, pwc, io, mrd, mwr, irw, rdst, m2r, rw, sa,
                sb, aop, psrc, dn, ill};
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // driver: one clock cycle in a given phase (entered at posedge+1)
    task automatic step(input phase_e ph, input bit mr, input bit z,
                        input logic [5:0] opc, input string tag);
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.opcode    = opc;
        #3;
        check($sformatf("%s/%s", tag, ph.name()), obs, expCtrl(ph, mr, z, opc));
        if (bus.instr_done === 1'b1) doneSeen++;
        @(posedge clk);
        #1;
    endtask

    task automatic memPhase(input phase_e ph, input int waits,
                            input logic [5:0] opc, input string tag);
        for (int i = 0; i < waits; i++) step(ph, 1'b0, 1'($urandom_range(0, 1)), opc, tag);
        step(ph, 1'b1, 1'($urandom_range(0, 1)), opc, tag);
    endtask

    // Run one full instruction; opcode held for its whole duration (as IR would be).
    task automatic doInstr(input logic [5:0] opc, input bit z, input int fw,
                           input int mw, input string tag);
        phase_e tail[$];
        doneSeen = 0;
        memPhase(P_FETCH, fw, opc, tag);
        step(P_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opc, tag);
        case (opc)
            6'h00: tail = '{P_EXECUTE, P_ALU_WB};
            6'h04: tail = '{P_BRANCH};
            6'h02: tail = '{P_JUMP};
            6'h08: if (ADDI_EN) tail = '{P_ADDI_EXEC, P_ADDI_WB};
            default: ;
        endcase
        if (opc == 6'h23) begin
            step(P_MEM_ADDR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opc, tag);
            memPhase(P_MEM_READ, mw, opc, tag);
            tail = '{P_MEM_WB};
        end else if (opc == 6'h2B) begin
            step(P_MEM_ADDR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opc, tag);
            memPhase(P_MEM_WRITE, mw, opc, tag);
        end
        foreach (tail[i])
            step(tail[i], 1'($urandom_range(0, 1)),
                 (tail[i] == P_BRANCH) ? z : 1'($urandom_range(0, 1)), opc, tag);
        check({tag, "/done_count"}, 19'(doneSeen), legalOp(opc) ? 19'd1 : 19'd0);
    endtask

    logic [5:0] pool [8];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        bus.opcode    = 6'h00;
        pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h15};

        // reset held: everything low even with mem_ready high
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", obs, 19'd0);
        rst_n = 1'b1;

        // lw, no waits; first FETCH is the cycle right after release
        doInstr(6'h23, 1'b0, 0, 0, "lw_nowait");
        // sw with three not-ready cycles in MEM_WRITE
        doInstr(6'h2B, 1'b0, 0, 3, "sw_wait3");
        // beq taken / not taken
        doInstr(6'h04, 1'b1, 0, 0, "beq_taken");
        doInstr(6'h04, 1'b0, 0, 0, "beq_not_taken");
        // R-type and jump, with fetch waits
        doInstr(6'h00, 1'b0, 2, 0, "rtype_fwait");
        doInstr(6'h02, 1'b0, 1, 0, "jump");
        // unsupported opcodes
        doInstr(6'h3F, 1'b0, 0, 0, "illegal_3f");
        doInstr(6'h08, 1'b0, 0, 0, "addi_08");

        // reset in the middle of a stalled store
        bus.opcode = 6'h2B;
        step(P_FETCH, 1'b1, 1'b0, 6'h2B, "sw_abort");
        step(P_DECODE, 1'b0, 1'b0, 6'h2B, "sw_abort");
        step(P_MEM_ADDR, 1'b0, 1'b0, 6'h2B, "sw_abort");
        step(P_MEM_WRITE, 1'b0, 1'b0, 6'h2B, "sw_abort");
        bus.mem_ready = 1'b0;
        #3;
        check("sw_abort/pre_reset", obs, expCtrl(P_MEM_WRITE, 1'b0, 1'b0, 6'h2B));
        rst_n = 1'b0;
        #1;
        check("sw_abort/async_drop", obs, 19'd0);
        @(posedge clk);
        #1;
        check("sw_abort/held", obs, 19'd0);
        rst_n = 1'b1;
        doInstr(6'h00, 1'b0, 0, 0, "after_abort");

        // random instruction stream
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = (n % 5 == 4) ? 6'($urandom) : pool[$urandom_range(0, 7)];
            doInstr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                    $urandom_range(0, 3), $sformatf("rand%0d_op%02h", n, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
